// File: rtl/mac_acc_quant_pkg.sv
// mac_acc_quant_pkg: shared widths, saturation limits and FSM state type for mac_acc_quant
package mac_acc_quant_pkg;
    localparam int PSUM_W  = 24;
    localparam int ACC_W   = 32;
    localparam int OUT_W   = 4;
    localparam int SHIFT_W = 5;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] OUT_MAX = '1;
    typedef enum logic [1:0] {IDLE, ACCUM, QUANT, OUT} state_t;
endpackage

// File: rtl/mac_acc_quant_sat_add.sv
// mac_acc_quant_sat_add: signed saturating adder with overflow flag
// Ports: a, b (signed W-bit operands), y (clamped signed sum), ovf (sum was clamped)
module mac_acc_quant_sat_add
    import mac_acc_quant_pkg::*;
#(
    parameter int W = ACC_W
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y,
    output logic                ovf
);
    logic signed [W:0] s;
    always_comb begin
        s   = {a[W-1], a} + {b[W-1], b};
        ovf = s[W] != s[W-1];
        y   = ovf ? {s[W], {(W-1){~s[W]}}} : s[W-1:0];
    end
endmodule

// File: rtl/mac_acc_quant.sv
// mac_acc_quant: accumulate MAC partial sums per group, add bias, shift, ReLU and saturate to OUT_W bits
// Ports: clk, rstn (async active-low); psum_valid/psum_ready/psum_data/psum_last input stream;
//        cfg_bias/cfg_shift sampled on a group's first beat; out_valid/out_ready/out_data result;
//        acc_ovf sticky accumulator-saturation flag for the current group.
// Build option: MAC_ACC_QUANT_ROUND_EN selects round-half-up instead of floor before the shift.
module mac_acc_quant
    import mac_acc_quant_pkg::*;
(
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      psum_valid,
    output logic                      psum_ready,
    input  logic signed [PSUM_W-1:0]  psum_data,
    input  logic                      psum_last,
    input  logic signed [ACC_W-1:0]   cfg_bias,
    input  logic [SHIFT_W-1:0]        cfg_shift,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic                      acc_ovf
);
    state_t st;
    logic signed [ACC_W-1:0] acc, bias_q, pext, acc_sum, t, tr, r;
    logic [SHIFT_W-1:0] shift_q;
    logic acc_sat, bias_ovf_unused;
    logic [OUT_W-1:0] q;

    assign pext       = {{(ACC_W-PSUM_W){psum_data[PSUM_W-1]}}, psum_data};
    assign psum_ready = (st == IDLE) || (st == ACCUM);

    mac_acc_quant_sat_add #(.W(ACC_W)) u_acc (.a(acc), .b(pext), .y(acc_sum), .ovf(acc_sat));
    mac_acc_quant_sat_add #(.W(ACC_W)) u_bias (.a(acc), .b(bias_q), .y(t), .ovf(bias_ovf_unused));

`ifdef MAC_ACC_QUANT_ROUND_EN
    logic signed [ACC_W-1:0] rnd;
    logic rnd_ovf_unused;
    assign rnd = (shift_q == '0) ? '0 : ACC_W'(1) << (shift_q - 1'b1);
    mac_acc_quant_sat_add #(.W(ACC_W)) u_rnd (.a(t), .b(rnd), .y(tr), .ovf(rnd_ovf_unused));
`else
    assign tr = t;
`endif

    // a negative r clamps to 0; any set bit above the output field clamps to OUT_MAX
    always_comb begin
        r = tr >>> shift_q;
        q = r[ACC_W-1] ? '0 : (|r[ACC_W-2:OUT_W]) ? OUT_MAX : r[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st        <= IDLE;
            acc       <= '0;
            bias_q    <= '0;
            shift_q   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            acc_ovf   <= 1'b0;
        end else begin
            case (st)
                IDLE: if (psum_valid) begin
                    acc     <= pext;
                    bias_q  <= cfg_bias;
                    shift_q <= cfg_shift;
                    acc_ovf <= 1'b0;
                    st      <= psum_last ? QUANT : ACCUM;
                end
                ACCUM: if (psum_valid) begin
                    acc     <= acc_sum;
                    acc_ovf <= acc_ovf | acc_sat;
                    st      <= psum_last ? QUANT : ACCUM;
                end
                QUANT: begin
                    out_data  <= q;
                    out_valid <= 1'b1;
                    st        <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    acc       <= '0;
                    st        <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule
